pattern_detector: RTL and testbench

- Byte-serial pattern lock detector on a received data stream, e.g. a PRBS/framing checker front end.
- Compares each incoming bus word against a fixed multi-byte pattern, least-significant byte first.
- Asserts a registered lock flag once the complete pattern has been received a programmed number of times back-to-back with no errors.
- Any byte error drops the flag and restarts the count.

---
 rtl/pattern_detector_if.sv | 10 +
 rtl/pattern_detector.sv | 72 +++++++
 tb/tb_pattern_detector.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pattern_detector_if.sv
// rtl/pattern_detector_if.sv - received byte stream in, lock flag out
interface pattern_detector_if #(
    parameter int BusWidth = 8
);
    logic [BusWidth-1:0] InData;
    logic                Flag;

    modport master (output InData, input Flag);
    modport slave  (input InData, output Flag);
endinterface

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - byte-serial pattern lock detector
// Raises Flag after NumRepeat back-to-back error-free patterns; any byte error drops it.
module pattern_detector #(
    parameter int                                  BusWidth     = 8,
    parameter int                                  PatternWords = 4,
    parameter logic [BusWidth*PatternWords-1:0]    Pattern      = 32'hAABBCCDD,
    parameter int                                  NumRepeat    = 4,
    parameter int                                  CntWidth     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    pattern_detector_if.slave    bus
);
    localparam int IdxWidth = (PatternWords > 1) ? $clog2(PatternWords) : 1;
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(PatternWords - 1);
    localparam logic [IdxWidth-1:0] AfterW0  = (PatternWords > 1) ? IdxWidth'(1) : '0;
    localparam logic [CntWidth-1:0] CntFull  = CntWidth'(NumRepeat);
    localparam logic [BusWidth-1:0] Word0    = Pattern[BusWidth-1:0];

    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic [BusWidth-1:0] exp_word;
    logic                match;

    always_comb begin
        exp_word = '0;
        for (int i = 0; i < PatternWords; i++) begin
            if (idx_q == IdxWidth'(i)) begin
                exp_word = Pattern[BusWidth*i +: BusWidth];
            end
        end
    end

    assign match = (bus.InData == exp_word);

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (match) begin
            if (idx_q == LastIdx) begin
                idx_d = '0;
                if (cnt_q != CntFull) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
                flag_d = (cnt_d == CntFull);
            end else begin
                idx_d = idx_q + IdxWidth'(1);
            end
        end else begin
            cnt_d  = '0;
            flag_d = 1'b0;
            // A mismatching byte that equals word 0 is taken as the start of a new pattern
            idx_d  = (bus.InData == Word0) ? AfterW0 : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign bus.Flag = flag_q;
endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - scoreboard bench for pattern_detector
module tb_pattern_detector;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    int   run    = 0;
    logic exp_q [$];
    logic [7:0] pat [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

    pattern_detector_if #(.BusWidth(8)) bus ();

    pattern_detector #(
        .BusWidth(8), .PatternWords(4), .Pattern(32'hAABBCCDD),
        .NumRepeat(4), .CntWidth(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Stream model: length of the current in-order run of correct bytes; lock at 4 full patterns
    task automatic send(input string tag, input logic [7:0] b);
        @(negedge CLK);
        bus.InData = b;
        if (b == pat[run % 4]) run++;
        else run = (b == pat[0]) ? 1 : 0;
        exp_q.push_back(run >= 16);
        @(posedge CLK);
        #1;
        check_eq(tag, {31'b0, bus.Flag}, {31'b0, exp_q.pop_front()});
    endtask

    task automatic send_pat(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send(tag, b0);
        send(tag, b1);
        send(tag, b2);
        send(tag, b3);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_eq("reset_flag", {31'b0, bus.Flag}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        run = 0;
    endtask

    initial begin
        RST = 1'b1;
        bus.InData = 8'h00;
        do_reset();

        for (int r = 0; r < 10; r++) send_pat("good_x10", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        check_eq("good_locked_end", {31'b0, bus.Flag}, 32'd1);

        do_reset();
        for (int r = 0; r < 10; r++) send_pat("byte_err", 8'hDD, 8'hCC, 8'h44, 8'hAA);
        check_eq("byte_err_end", {31'b0, bus.Flag}, 32'd0);

        do_reset();
        for (int r = 0; r < 10; r++) send_pat("bit_err", 8'hDD, 8'hCD, 8'hBB, 8'hAA);
        check_eq("bit_err_end", {31'b0, bus.Flag}, 32'd0);

        do_reset();
        send_pat("restart", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        send_pat("restart", 8'hDD, 8'hCD, 8'hBB, 8'hAA);
        for (int r = 0; r < 3; r++) send_pat("restart", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        check_eq("restart_cnt3", {31'b0, bus.Flag}, 32'd0);
        send_pat("restart_4th", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        check_eq("restart_lock", {31'b0, bus.Flag}, 32'd1);

        send_pat("drop", 8'hDD, 8'hCC, 8'h00, 8'hAA);
        check_eq("drop_flag", {31'b0, bus.Flag}, 32'd0);
        for (int r = 0; r < 3; r++) send_pat("relock", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        check_eq("relock_3", {31'b0, bus.Flag}, 32'd0);
        send_pat("relock", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        check_eq("relock_4", {31'b0, bus.Flag}, 32'd1);

        send("mid", 8'hDD);
        send("mid", 8'hCC);
        check_eq("pre_async", {31'b0, bus.Flag}, 32'd1);
        #2;
        RST = 1'b0;
        #0.5;
        check_eq("async_rst", {31'b0, bus.Flag}, 32'd0);
        #0.5;
        RST = 1'b1;
        run = 0;
        for (int r = 0; r < 4; r++) send_pat("after_rst", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        check_eq("after_rst_lock", {31'b0, bus.Flag}, 32'd1);

        do_reset();
        send("resync", 8'hDD);
        send_pat("resync", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        for (int r = 0; r < 3; r++) send_pat("resync", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        check_eq("resync_lock", {31'b0, bus.Flag}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            b = pat[run % 4];
            if ($urandom_range(0, 39) == 0) b = 8'(b ^ (8'd1 << $urandom_range(0, 7)));
            else if ($urandom_range(0, 59) == 0) b = pat[0];
            send("random", b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
